// File: rtl/sik_pkg.sv
// sik_pkg: shared op encodings, stack-unit FSM states and word width for the SIK processor.
package sik_pkg;
  localparam int WORDSIZE = 16;
  localparam logic [2:0] SK_PUSH = 3'd0;
  localparam logic [2:0] SK_POP  = 3'd1;
  localparam logic [2:0] SK_POP2 = 3'd2;
  localparam logic [2:0] SK_GET  = 3'd3;
  localparam logic [2:0] SK_PUT  = 3'd4;
  localparam logic [2:0] SK_DUP  = 3'd5;
  typedef enum logic [2:0] {ST_IDLE, ST_RD1, ST_RD2, ST_WB, ST_RESP} sik_state_e;
endpackage

// File: rtl/sik_stack_ram.sv
// sik_stack_ram: single-port data stack RAM, synchronous read and write-enable.
module sik_stack_ram import sik_pkg::*; #(
  parameter int WIDTH = WORDSIZE,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/sik_stack_unit.sv
// sik_stack_unit: stack-memory responder servicing push/pop/pop2/get/put/dup over valid/ready.
module sik_stack_unit import sik_pkg::*; #(
  parameter int WIDTH = WORDSIZE,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH),
  localparam int DW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [7:0]       req_arg,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data0,
  output logic [WIDTH-1:0] rsp_data1,
  output logic             rsp_err,
  output logic [DW-1:0]    depth
);
  sik_state_e state_q;
  logic [2:0] op_q;
  logic [DW-1:0] depth_q, depth_d, top_a, sec_a, off_a, k;
  logic [WIDTH-1:0] data0_q, data1_q, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic valid_q, err_q, req_err, full, empty, ram_we, wr_op;
  always_comb begin
    k = DW'(req_arg);
    full = depth_q == DW'(DEPTH);
    empty = depth_q == '0;
    top_a = depth_q - DW'(1);
    sec_a = depth_q - DW'(2);
    off_a = top_a - k;
    wr_op = req_op == SK_PUSH || req_op == SK_PUT;
    req_err = (req_op == SK_PUSH) ? full :
              (req_op == SK_POP)  ? empty :
              (req_op == SK_POP2) ? depth_q < DW'(2) :
              (req_op == SK_GET || req_op == SK_PUT) ? k >= depth_q :
              (req_op == SK_DUP)  ? (empty || full) : 1'b1;
    // IDLE-cycle writes go straight to the RAM so PUSH/PUT respond one cycle after accept
    ram_we = (state_q == ST_IDLE && reset && req_valid && !req_err && wr_op) || state_q == ST_WB;
    ram_addr = (state_q == ST_WB)  ? depth_q[AW-1:0] :
               (state_q == ST_RD1) ? sec_a[AW-1:0] :
               (req_op == SK_PUSH) ? depth_q[AW-1:0] :
               (req_op == SK_GET || req_op == SK_PUT) ? off_a[AW-1:0] : top_a[AW-1:0];
    ram_wdata = (state_q == ST_WB) ? data0_q : req_data;
    depth_d = err_q ? depth_q :
              (op_q == SK_PUSH || op_q == SK_DUP) ? depth_q + DW'(1) :
              (op_q == SK_POP)  ? depth_q - DW'(1) :
              (op_q == SK_POP2) ? depth_q - DW'(2) : depth_q;
  end
  sik_stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .we(ram_we), .addr(ram_addr), .wdata(ram_wdata), .rdata(ram_rdata)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q <= SK_PUSH;
      depth_q <= '0;
      data0_q <= '0;
      data1_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid) begin
          op_q <= req_op;
          err_q <= req_err;
          data0_q <= '0;
          data1_q <= '0;
          state_q <= (req_err || wr_op) ? ST_RESP : ST_RD1;
          valid_q <= req_err || wr_op;
        end
        ST_RD1: begin
          data0_q <= ram_rdata;
          state_q <= (op_q == SK_POP2) ? ST_RD2 : (op_q == SK_DUP) ? ST_WB : ST_RESP;
          valid_q <= op_q != SK_POP2 && op_q != SK_DUP;
        end
        ST_RD2: begin
          data1_q <= ram_rdata;
          state_q <= ST_RESP;
          valid_q <= 1'b1;
        end
        ST_WB: begin
          state_q <= ST_RESP;
          valid_q <= 1'b1;
        end
        ST_RESP: if (rsp_ready) begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          depth_q <= depth_d;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign req_ready = state_q == ST_IDLE;
  assign rsp_valid = valid_q;
  assign rsp_data0 = data0_q;
  assign rsp_data1 = data1_q;
  assign rsp_err = err_q;
  assign depth = depth_q;
endmodule

// File: doc/sik_stack_unit.md
# sik_stack_unit

Stack-memory responder for the SIK stack processor: it services the core's push/pop/get/put/dup requests over a valid/ready handshake and owns the stack pointer and data stack storage. The processor core is the initiator and issues one stack request per micro-step. `sik_stack_unit` is the responding end: it performs the access, tracks depth, and returns data plus an error flag on overflow, underflow or a bad offset.

## Interface
- `WIDTH`, 16, data word width (matches `WORDSIZE`).
- `DEPTH`, 256, stack entries; power of two.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_op`  in  3  0 PUSH, 1 POP, 2 POP2, 3 GET, 4 PUT, 5 DUP, 6–7 illegal.
- `req_arg`  in  8  depth offset k for GET/PUT (0 = top of stack).
- `req_data`  in  WIDTH  write data for PUSH/PUT.
- `rsp_valid`  out  1  response present; held until accepted.
- `rsp_ready`  in  1  core accepts response.
- `rsp_data0`  out  WIDTH  top / read value.
- `rsp_data1`  out  WIDTH  second item (POP2 only, else 0).
- `rsp_err`  out  1  request rejected; stack unchanged.
- `depth`  out  clog2(DEPTH)+1  current item count.

## Operation
- Stack model: `depth` counts items. Top of stack is at `mem[depth-1]`; offset k addresses `mem[depth-1-k]`.
- PUSH: write `req_data` at `mem[depth]`, then `depth+1`. Error if `depth==DEPTH`.
- POP: `rsp_data0 = top`, then `depth-1`. Error if `depth==0`.
- POP2: `rsp_data0 = top`, `rsp_data1 = next`, then `depth-2`. Error if `depth<2`.
- GET: `rsp_data0 = mem[depth-1-k]`. Depth unchanged. Error if `k>=depth`.
- PUT: `mem[depth-1-k] = req_data`. Depth unchanged. Error if `k>=depth`.
- DUP: read top, write it at `mem[depth]`, `depth+1`, `rsp_data0 = top`. Error if `depth==0` or `depth==DEPTH`.
- Illegal op: error.
- On any error: no memory write, no depth change, `rsp_data0`/`rsp_data1` = 0, `rsp_err=1`.
- FSM states: IDLE, RD1, RD2, WB, RESP.
  - IDLE: on accept, error → RESP; PUSH/PUT → write this cycle → RESP; POP/GET/DUP/POP2 → issue read → RD1.
  - RD1: capture word into `rsp_data0`. POP/GET → RESP; POP2 → issue second read → RD2; DUP → WB.
  - RD2: capture `rsp_data1` → RESP.
  - WB: write the captured word at `mem[depth]` → RESP.
  - RESP: `rsp_valid=1`; on `rsp_ready` → IDLE.
- `depth` updates in the cycle the response handshake completes, so `depth` always reflects completed operations.
- Arithmetic: addresses are computed modulo DEPTH from a `depth` that is clog2(DEPTH)+1 bits wide. `depth` never wraps; bound checks happen before any access.

## Timing
- Reset values (reset low at a rising edge): state IDLE, `depth=0`, `req_ready=1`, `rsp_valid=0`, `rsp_data0=0`, `rsp_data1=0`, `rsp_err=0`. Memory contents are not cleared.
- Reset mid-operation aborts the operation. A write already issued in IDLE or WB stands; no response is produced.
- Latency from accept to `rsp_valid`:
  - PUSH/PUT/error: 1 cycle.
  - POP/GET: 2 cycles.
  - POP2/DUP: 3 cycles.
- Response handshake: `rsp_valid` and data are stable until `rsp_ready`. `req_ready` goes high the cycle after the response handshake.
- Peak throughput: one request per 2 cycles.
- `req_*` are sampled only in the accept cycle; later changes are ignored.
- The RAM is single-port with synchronous read: read data is valid the cycle after the address.

## Structure
- A shared package `sik_pkg` holds the op encodings (`SK_PUSH` … `SK_DUP`), the state enum, and the `WORDSIZE` width constant. The processor core uses the same op constants.
- Sub-module `sik_stack_ram`: DEPTH×WIDTH single-port RAM with synchronous read and write-enable. All control logic stays in `sik_stack_unit`.

## Test plan
- Reset low for 2 cycles, then release → `depth=0`, `req_ready=1`, `rsp_valid=0`. POP → `rsp_err=1` one cycle after accept, `depth` stays 0.
- PUSH 0x1234, PUSH 0xABCD, then POP2 → `rsp_data0=0xABCD`, `rsp_data1=0x1234`, `rsp_valid` 3 cycles after accept, `depth` back to 0.
- PUSH 5, 6, 7; GET k=2 → `rsp_data0=5`. PUT k=1 data 0x00FF, then POP twice → 7 then 0x00FF, `depth=1`. GET k=1 → `rsp_err=1`.
- Fill with 256 PUSHes (value = index) → `depth=256`. PUSH → err. DUP → err. POP → 255, `depth=255`.
- PUSH 9, DUP, hold `rsp_ready=0` for 4 cycles → `rsp_valid` and `rsp_data0=9` held, `req_ready=0`. Release → `depth=2`. POP2 → 9, 9.
- Issue POP2 with `depth=3`, assert reset in RD2 → no `rsp_valid`, `depth=0`. Op 7 → `rsp_err=1`.
